vpifo_pop_scheduler: RTL and testbench

Pop-side controller for the multi-tree vPIFO task generator. It sits between the trace reader and the task generator. It admits push requests per tree against a per-tree capacity, and tracks the occupancy of each logical tree. It issues rate-limited pops, choosing a non-empty tree round-robin, so all trees share the single pop port fairly.

---
 rtl/vpifo_sched_pkg.sv | 20 ++
 rtl/vpifo_pop_scheduler_rr_pick.sv | 34 +++
 rtl/vpifo_pop_scheduler.sv | 140 ++++++++++++++
 tb/tb_vpifo_pop_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vpifo_sched_pkg.sv
// Shared types and helpers for the vPIFO pop scheduler: FSM state encoding,
// gap-counter sizing and a saturating increment.
package vpifo_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // The gap counter runs 0..POP_GAP-2, so it never needs more than clog2(POP_GAP) bits.
  function automatic int gap_cnt_width(input int pop_gap);
    return (pop_gap <= 2) ? 1 : $clog2(pop_gap);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/vpifo_pop_scheduler_rr_pick.sv
// Round-robin picker: first set bit of i_mask at or above i_ptr, wrapping
// modulo TREE_NUM (which need not be a power of two).
module rr_pick #(
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM)
) (
  input  logic [TREE_NUM-1:0]      i_mask,
  input  logic [TREE_NUM_BITS-1:0] i_ptr,
  output logic [TREE_NUM_BITS-1:0] o_grant,
  output logic                     o_valid
);

  int                       idx;
  logic [TREE_NUM_BITS-1:0] sel;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < TREE_NUM; k++) begin
      idx = int'(i_ptr) + k;
      if (idx >= TREE_NUM) begin
        idx = idx - TREE_NUM;
      end
      sel = TREE_NUM_BITS'(idx);
      if (!o_valid && i_mask[sel]) begin
        o_valid = 1'b1;
        o_grant = sel;
      end
    end
  end

endmodule

// File: rtl/vpifo_pop_scheduler.sv
// Pop-side controller for the multi-tree vPIFO: per-tree push admission and
// occupancy tracking, plus rate-limited round-robin pop issue.
module vpifo_pop_scheduler
  import vpifo_sched_pkg::*;
#(
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int CTW           = 16,
  parameter int TREE_CAP      = 64,
  parameter int POP_GAP       = 4
) (
  input  logic                     i_clk,
  input  logic                     i_arst,
  input  logic                     i_push,
  input  logic [TREE_NUM_BITS-1:0] i_push_tree_id,
  input  logic                     i_task_fifo_full,
  input  logic                     i_pop_en,
  output logic                     o_push_ready,
  output logic                     o_push,
  output logic                     o_pop,
  output logic [TREE_NUM_BITS-1:0] o_pop_tree_id,
  output logic                     o_busy,
  output logic [CTW-1:0]           o_reject_cnt
);

  localparam int               GAP_W    = gap_cnt_width(POP_GAP);
  localparam logic [CTW-1:0]   CAP_V    = CTW'(TREE_CAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POP_GAP >= 2) ? POP_GAP - 2 : 0);

  logic [CTW-1:0]           cnt_q [TREE_NUM];
  logic [CTW-1:0]           cnt_d [TREE_NUM];
  logic [TREE_NUM-1:0]      nonempty;
  logic [TREE_NUM-1:0]      nonempty_next;
  logic [TREE_NUM-1:0]      inc;
  logic [TREE_NUM-1:0]      dec;

  state_e                   state_q, state_d;
  logic [TREE_NUM_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [TREE_NUM_BITS-1:0] grant_q, grant_d;
  logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
  logic                     pop_q, pop_d;
  logic                     busy_q, busy_d;
  logic [CTW-1:0]           reject_q, reject_d;

  logic                     id_ok;
  logic [CTW-1:0]           sel_cnt;
  logic [TREE_NUM_BITS-1:0] pick_grant;
  logic                     pick_valid;

  // Out-of-range ids only exist for non-power-of-two TREE_NUM; they are refused.
  assign id_ok        = int'(i_push_tree_id) < TREE_NUM;
  assign sel_cnt      = id_ok ? cnt_q[i_push_tree_id] : '0;
  assign o_push_ready = !i_task_fifo_full && id_ok && (sel_cnt < CAP_V);
  assign o_push       = i_push && o_push_ready;

  genvar gi;
  generate
    for (gi = 0; gi < TREE_NUM; gi++) begin : g_tree
      assign inc[gi]      = o_push && (i_push_tree_id == TREE_NUM_BITS'(gi));
      assign dec[gi]      = (state_q == S_POP) && (grant_q == TREE_NUM_BITS'(gi));
      // A push and a pop on the same tree in one cycle cancel out.
      assign cnt_d[gi]    = (inc[gi] && !dec[gi]) ? cnt_q[gi] + 1'b1 :
                            (dec[gi] && !inc[gi]) ? cnt_q[gi] - 1'b1 : cnt_q[gi];
      assign nonempty[gi]      = cnt_q[gi] != '0;
      assign nonempty_next[gi] = cnt_d[gi] != '0;
    end
  endgenerate

  assign busy_d   = |nonempty_next;
  assign reject_d = (i_push && !o_push_ready)
                  ? CTW'(sat_inc(32'(reject_q), 32'({CTW{1'b1}})))
                  : reject_q;

  rr_pick #(
    .TREE_NUM      (TREE_NUM),
    .TREE_NUM_BITS (TREE_NUM_BITS)
  ) u_rr_pick (
    .i_mask  (nonempty),
    .i_ptr   (rr_ptr_q),
    .o_grant (pick_grant),
    .o_valid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_pop_en && pick_valid) begin
          grant_d = pick_grant;
          state_d = S_POP;
        end
      end
      S_POP: begin
        rr_ptr_d  = (int'(grant_q) == TREE_NUM - 1) ? '0 : grant_q + 1'b1;
        gap_cnt_d = '0;
        state_d   = (POP_GAP == 1) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pop_d = (state_d == S_POP);
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cnt_q     <= '{default: '0};
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      gap_cnt_q <= '0;
      pop_q     <= 1'b0;
      busy_q    <= 1'b0;
      reject_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      gap_cnt_q <= gap_cnt_d;
      pop_q     <= pop_d;
      busy_q    <= busy_d;
      reject_q  <= reject_d;
    end
  end

  assign o_pop         = pop_q;
  assign o_pop_tree_id = grant_q;
  assign o_busy        = busy_q;
  assign o_reject_cnt  = reject_q;

endmodule

// File: tb/tb_vpifo_pop_scheduler.sv
// Directed and randomized checks of vpifo_pop_scheduler against a cycle-count
// reference model (occupancy array, last-pop time, round-robin pointer).
module tb_vpifo_pop_scheduler;

  localparam int N   = 4;
  localparam int NB  = 2;
  localparam int CTW = 16;
  localparam int CAP = 64;
  localparam int GAP = 4;
  localparam int REJ_MAX = (1 << CTW) - 1;

  logic          clk  = 1'b0;
  logic          arst = 1'b1;
  logic          push = 1'b0;
  logic [NB-1:0] tid  = '0;
  logic          full = 1'b0;
  logic          en   = 1'b0;
  logic          o_push_ready, o_push, o_pop, o_busy;
  logic [NB-1:0] o_pop_tree_id;
  logic [CTW-1:0] o_reject_cnt;

  vpifo_pop_scheduler #(
    .TREE_NUM(N), .TREE_NUM_BITS(NB), .CTW(CTW), .TREE_CAP(CAP), .POP_GAP(GAP)
  ) dut (
    .i_clk            (clk),
    .i_arst           (arst),
    .i_push           (push),
    .i_push_tree_id   (tid),
    .i_task_fifo_full (full),
    .i_pop_en         (en),
    .o_push_ready     (o_push_ready),
    .o_push           (o_push),
    .o_pop            (o_pop),
    .o_pop_tree_id    (o_pop_tree_id),
    .o_busy           (o_busy),
    .o_reject_cnt     (o_reject_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: occupancy seen this cycle, pointer, time of last pop.
  int   mcnt [N];
  int   mrr;
  int   mlast;
  int   mcyc;
  logic mpop;
  int   mpop_id;
  logic mbusy;
  int   mrej;
  int   pop_cyc [$];
  int   pop_tree [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mrr = 0; mlast = -1000; mcyc = 0;
    mpop = 1'b0; mpop_id = 0; mbusy = 1'b0; mrej = 0;
  endtask

  // One clock cycle: compare all outputs with the model, then advance the model.
  task automatic step();
    logic rdy;
    logic any_now;
    logic any_next;
    logic nxt_pop;
    int   nxt_id;
    int   t;
    int   j;
    #1;
    t   = int'(tid);
    rdy = !full && (t < N) && (mcnt[t] < CAP);
    chk("push_ready", 32'(o_push_ready), 32'(rdy));
    chk("push_fwd", 32'(o_push), 32'(push && rdy));
    chk("pop", 32'(o_pop), 32'(mpop));
    if (mpop) chk("pop_tree", 32'(o_pop_tree_id), 32'(mpop_id));
    chk("busy", 32'(o_busy), 32'(mbusy));
    chk("reject_cnt", 32'(o_reject_cnt), 32'(mrej));
    if (o_pop === 1'b1) begin
      pop_cyc.push_back(mcyc);
      pop_tree.push_back(int'(o_pop_tree_id));
    end

    any_now = 1'b0;
    for (int i = 0; i < N; i++) if (mcnt[i] != 0) any_now = 1'b1;
    nxt_pop = 1'b0;
    nxt_id  = 0;
    if (!mpop && en && any_now && (mcyc - mlast >= GAP)) begin
      nxt_pop = 1'b1;
      for (int k = N - 1; k >= 0; k--) begin
        j = (mrr + k) % N;
        if (mcnt[j] != 0) nxt_id = j;
      end
    end
    if (push && rdy) mcnt[t] = mcnt[t] + 1;
    if (mpop) begin
      mcnt[mpop_id] = mcnt[mpop_id] - 1;
      mrr   = (mpop_id + 1) % N;
      mlast = mcyc;
    end
    if (push && !rdy && mrej < REJ_MAX) mrej = mrej + 1;
    any_next = 1'b0;
    for (int i = 0; i < N; i++) if (mcnt[i] != 0) any_next = 1'b1;
    mbusy   = any_next;
    mpop    = nxt_pop;
    mpop_id = nxt_id;
    mcyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 1'b0; full = 1'b0; en = 1'b0; tid = '0;
    arst = 1'b1;
    #2;
    chk("rst_pop", 32'(o_pop), 32'd0);
    chk("rst_pop_tree", 32'(o_pop_tree_id), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_reject", 32'(o_reject_cnt), 32'd0);
    chk("rst_ready", 32'(o_push_ready), 32'd1);
    @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();
  endtask

  task automatic push_one(input int tree);
    push = 1'b1;
    tid  = NB'(tree);
    step();
    push = 1'b0;
  endtask

  int rr_exp [6] = '{0, 1, 3, 0, 1, 3};
  int t0;

  initial begin
    model_reset();
    do_reset();
    repeat (3) step();

    // Single push to tree 2 with pops enabled
    pop_cyc.delete(); pop_tree.delete();
    en = 1'b1;
    t0 = mcyc;
    push_one(2);
    repeat (8) step();
    chk("single_npops", 32'(pop_cyc.size()), 32'd1);
    if (pop_cyc.size() >= 1) begin
      chk("single_latency", 32'(pop_cyc[0] - t0), 32'd2);
      chk("single_tree", 32'(pop_tree[0]), 32'd2);
    end

    // Round-robin over trees 0, 1, 3
    do_reset();
    push_one(0); push_one(0); push_one(1); push_one(1); push_one(3); push_one(3);
    pop_cyc.delete(); pop_tree.delete();
    en = 1'b1;
    repeat (40) step();
    chk("rr_npops", 32'(pop_cyc.size()), 32'd6);
    for (int i = 0; i < 6 && i < pop_cyc.size(); i++) begin
      chk("rr_order", 32'(pop_tree[i]), 32'(rr_exp[i]));
      if (i > 0) chk("rr_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'(GAP + 1));
    end

    // Capacity: 64 accepted, 65th refused, other tree still accepted
    do_reset();
    repeat (CAP) push_one(1);
    push_one(1);
    push_one(0);
    step();
    chk("cap_reject", 32'(o_reject_cnt), 32'd1);

    // Back-pressure: three refused pushes, occupancy untouched
    do_reset();
    push_one(0);
    full = 1'b1;
    push_one(1); push_one(2); push_one(0);
    full = 1'b0;
    step();
    chk("bp_reject", 32'(o_reject_cnt), 32'd3);
    pop_cyc.delete(); pop_tree.delete();
    en = 1'b1;
    repeat (20) step();
    chk("bp_npops", 32'(pop_cyc.size()), 32'd1);

    // Same-tree push during that tree's pop cycle
    do_reset();
    push_one(0);
    pop_cyc.delete(); pop_tree.delete();
    en = 1'b1;
    for (int k = 0; k < 20 && o_pop !== 1'b1; k++) step();
    push_one(0);
    repeat (15) step();
    chk("coll_npops", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2) begin
      chk("coll_spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'(GAP + 1));
      chk("coll_tree", 32'(pop_tree[1]), 32'd0);
    end

    // Reset asserted in the gap with cnt[1]=3
    do_reset();
    repeat (4) push_one(1);
    en = 1'b1;
    for (int k = 0; k < 20 && o_pop !== 1'b1; k++) step();
    step();
    chk("midgap_busy", 32'(o_busy), 32'd1);
    do_reset();
    pop_cyc.delete(); pop_tree.delete();
    en = 1'b1;
    repeat (10) step();
    chk("post_rst_npops", 32'(pop_cyc.size()), 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      push = ($urandom_range(0, 1) == 1);
      tid  = NB'($urandom_range(0, N - 1));
      full = ($urandom_range(0, 4) == 0);
      en   = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
